// File: rtl/iir_out_decim.sv
// Decimating output stage: keeps every DECIM-th IIR sample, converts it to DOUT_W bits and queues it in a small FIFO.
// Define IIR_OUT_ROUND_EN for round-half-up with saturation; otherwise the conversion is plain truncation.
module iir_out_decim #(
  parameter int unsigned DIN_W      = 24,
  parameter int unsigned DOUT_W     = 16,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          din_vld,
  input  logic [DIN_W-1:0]              din,
  output logic [DOUT_W-1:0]             dout,
  output logic                          dout_vld,
  input  logic                          dout_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned SH    = DIN_W - DOUT_W;

  logic [CNT_W-1:0]  r_dcnt;
  logic              r_s1_vld;
  logic [DOUT_W-1:0] r_s1_data;
  logic [DOUT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_dout_vld;
  logic [DOUT_W-1:0] r_dout;
  logic              r_ovf;

  logic [DOUT_W-1:0] w_conv;
  logic              w_keep;
  logic              w_full;
  logic              w_pop;
  logic              w_wr;
  logic              w_ovf_set;
  logic [PTR_W-1:0]  w_rd_nxt;
  logic [LVL_W-1:0]  w_level_nxt;

`ifdef IIR_OUT_ROUND_EN
  // Add half an output LSB, shift keeping one guard bit, then clamp on guard/sign disagreement.
  localparam logic [DIN_W:0] HALF = (DIN_W+1)'(1) << (SH - 1);
  logic [DIN_W:0]  w_sum;
  logic [DOUT_W:0] w_shift;

  assign w_sum   = {din[DIN_W-1], din} + HALF;
  assign w_shift = (DOUT_W+1)'(w_sum >> SH);

  always_comb begin
    w_conv = w_shift[DOUT_W-1:0];
    if (w_shift[DOUT_W] != w_shift[DOUT_W-1]) begin
      w_conv = w_shift[DOUT_W] ? {1'b1, {(DOUT_W-1){1'b0}}} : {1'b0, {(DOUT_W-1){1'b1}}};
    end
  end
`else
  assign w_conv = DOUT_W'(din >> SH);
`endif

  assign w_keep = din_vld && (r_dcnt == '0);

  // Decimation counter and conversion stage S1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dcnt    <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
    end else begin
      if (din_vld) begin
        r_dcnt <= (r_dcnt == CNT_W'(DECIM - 1)) ? '0 : r_dcnt + CNT_W'(1);
      end
      r_s1_vld <= w_keep;
      if (w_keep) begin
        r_s1_data <= w_conv;
      end
    end
  end

  // A full FIFO still takes the S1 sample when the head leaves in the same cycle.
  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop     = r_dout_vld & dout_rdy;
  assign w_wr      = r_s1_vld & (~w_full | w_pop);
  assign w_ovf_set = r_s1_vld & w_full & ~w_pop;
  assign w_rd_nxt  = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr && !w_pop) begin
      w_level_nxt = r_level + LVL_W'(1);
    end else if (!w_wr && w_pop) begin
      w_level_nxt = r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= r_s1_data;
    end
  end

  // Head is re-registered each cycle; a write landing on the next head slot bypasses the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_dout_vld <= 1'b0;
      r_dout     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr   <= w_rd_nxt;
      r_level    <= w_level_nxt;
      r_dout_vld <= (w_level_nxt != '0);
      r_dout     <= (w_wr && (r_wr_ptr == w_rd_nxt)) ? r_s1_data : r_mem[w_rd_nxt];
      if (ovf_clr) begin
        r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;
  assign level    = r_level;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_iir_out_decim.sv
// Directed and reference-model bench for iir_out_decim; instance A uses DECIM=1, instance B uses DECIM=4.
module tb_iir_out_decim;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_vld, a_rdy, a_clr, a_dout_vld, a_ovf;
  logic [23:0] a_din;
  logic [15:0] a_dout;
  logic [2:0]  a_level;

  logic        b_vld, b_rdy, b_clr, b_dout_vld, b_ovf;
  logic [23:0] b_din;
  logic [15:0] b_dout;
  logic [2:0]  b_level;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [23:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [8];
  logic [15:0] q [$];

  always #5 clk = ~clk;

  iir_out_decim #(.DIN_W(24), .DOUT_W(16), .DECIM(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .din_vld(a_vld), .din(a_din), .dout(a_dout), .dout_vld(a_dout_vld),
    .dout_rdy(a_rdy), .level(a_level), .ovf(a_ovf), .ovf_clr(a_clr)
  );

  iir_out_decim #(.DIN_W(24), .DOUT_W(16), .DECIM(4), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .din_vld(b_vld), .din(b_din), .dout(b_dout), .dout_vld(b_dout_vld),
    .dout_rdy(b_rdy), .level(b_level), .ovf(b_ovf), .ovf_clr(b_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe held across one rising edge; returns just after the edge that loads S1.
  task automatic a_strobe(input logic [23:0] v);
    a_din = v;
    a_vld = 1'b1;
    tick();
    a_vld = 1'b0;
  endtask

  function automatic logic [15:0] model_conv(input logic [23:0] d);
    logic signed [23:0] ds;
    int x;
    ds = d;
    x  = ds;
`ifdef IIR_OUT_ROUND_EN
    x = (x + 128) >>> 8;
    if (x > 32767)  x = 32767;
    if (x < -32768) x = -32768;
`else
    x = x >>> 8;
`endif
    return 16'(x);
  endfunction

  task automatic b_check_pop(input string name);
    if (b_dout_vld && b_rdy) begin
      if (q.size() == 0) begin
        chk({name, "_extra"}, 32'(b_dout), 32'hDEAD);
      end else begin
        chk(name, 32'(b_dout), 32'(q.pop_front()));
      end
    end
  endtask

  initial begin
`ifdef IIR_OUT_ROUND_EN
    tbl[0] = '{24'h000180, 16'h0002};
    tbl[1] = '{24'hFFFF80, 16'h0000};
    tbl[2] = '{24'h7FFF80, 16'h7FFF};
    tbl[3] = '{24'h800000, 16'h8000};
    tbl[4] = '{24'hFFFFFF, 16'h0000};
    tbl[5] = '{24'h123456, 16'h1234};
    tbl[6] = '{24'h1234C0, 16'h1235};
    tbl[7] = '{24'hFFFE7F, 16'hFFFE};
`else
    tbl[0] = '{24'h000180, 16'h0001};
    tbl[1] = '{24'hFFFF80, 16'hFFFF};
    tbl[2] = '{24'h7FFF80, 16'h7FFF};
    tbl[3] = '{24'h800000, 16'h8000};
    tbl[4] = '{24'hFFFFFF, 16'hFFFF};
    tbl[5] = '{24'h123456, 16'h1234};
    tbl[6] = '{24'h1234C0, 16'h1234};
    tbl[7] = '{24'hFFFE7F, 16'hFFFE};
`endif
    rst = 1'b0;
    a_vld = 1'b0; a_rdy = 1'b0; a_clr = 1'b0; a_din = '0;
    b_vld = 1'b0; b_rdy = 1'b0; b_clr = 1'b0; b_din = '0;
    tick(); tick();
    chk("rst_vld",   32'(a_dout_vld), 32'd0);
    chk("rst_level", 32'(a_level),    32'd0);
    chk("rst_ovf",   32'(a_ovf),      32'd0);
    chk("rst_dout",  32'(a_dout),     32'd0);
    chk("rst_b_vld", 32'(b_dout_vld), 32'd0);
    rst = 1'b1;
    tick();

    // Conversion vectors, one sample at a time with the consumer always ready
    a_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_strobe(tbl[i].din);
      tick();
      chk($sformatf("conv%0d_vld", i),  32'(a_dout_vld), 32'd1);
      chk($sformatf("conv%0d_dout", i), 32'(a_dout),     32'(tbl[i].exp));
      tick();
      chk($sformatf("conv%0d_empty", i), 32'(a_dout_vld), 32'd0);
    end

    // Decimation by 4: only strobes 1 and 5 survive, each visible for one cycle
    b_rdy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      logic keep;
      keep  = ((k - 1) % 4) == 0;
      b_din = 24'(k * 256);
      b_vld = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        tick();
        if (c == 1) b_vld = 1'b0;
        chk($sformatf("dec_k%0d_c%0d_vld", k, c), 32'(b_dout_vld), 32'(keep && (c == 2)));
        if (keep && (c == 2)) chk($sformatf("dec_k%0d_dout", k), 32'(b_dout), 32'(k));
      end
    end
    b_rdy = 1'b0;

    // Overflow: five back-to-back samples into a stalled FIFO
    a_rdy = 1'b0;
    for (int k = 1; k <= 5; k++) a_strobe(24'(k << 8));
    tick();
    chk("ovf_level", 32'(a_level), 32'd4);
    chk("ovf_flag",  32'(a_ovf),   32'd1);
    a_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_drain%0d", k), 32'(a_dout), 32'(k));
      chk($sformatf("ovf_drain%0d_vld", k), 32'(a_dout_vld), 32'd1);
      tick();
    end
    a_rdy = 1'b0;
    chk("ovf_drained_level", 32'(a_level),    32'd0);
    chk("ovf_drained_vld",   32'(a_dout_vld), 32'd0);
    chk("ovf_sticky",        32'(a_ovf),      32'd1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("ovf_cleared", 32'(a_ovf), 32'd0);

    // Full FIFO with a pop in the write cycle, then clear racing a new overflow
    for (int k = 1; k <= 4; k++) a_strobe(24'(k << 8));
    tick();
    chk("full_level", 32'(a_level), 32'd4);
    chk("full_head",  32'(a_dout),  32'd1);
    a_strobe(24'(9 << 8));
    a_rdy = 1'b1;
    tick();
    a_rdy = 1'b0;
    chk("fullpop_level", 32'(a_level), 32'd4);
    chk("fullpop_ovf",   32'(a_ovf),   32'd0);
    chk("fullpop_head",  32'(a_dout),  32'd2);
    a_strobe(24'(10 << 8));
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("clrprio_ovf",   32'(a_ovf),   32'd0);
    chk("clrprio_level", 32'(a_level), 32'd4);
    a_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] e;
      e = (k == 3) ? 16'd9 : 16'(k + 2);
      chk($sformatf("fullpop_drain%0d", k), 32'(a_dout), 32'(e));
      tick();
    end
    a_rdy = 1'b0;
    chk("fullpop_empty", 32'(a_level), 32'd0);

    // Asynchronous reset with three queued samples and one in S1
    for (int k = 1; k <= 4; k++) a_strobe(24'(k << 8));
    chk("midrst_level_before", 32'(a_level), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_vld",   32'(a_dout_vld), 32'd0);
    chk("midrst_level", 32'(a_level),    32'd0);
    chk("midrst_dout",  32'(a_dout),     32'd0);
    chk("midrst_ovf",   32'(a_ovf),      32'd0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    chk("postrst_no_ghost", 32'(a_dout_vld), 32'd0);
    a_strobe(24'(7 << 8));
    tick();
    chk("postrst_vld",   32'(a_dout_vld), 32'd1);
    chk("postrst_dout",  32'(a_dout),     32'd7);
    chk("postrst_level", 32'(a_level),    32'd1);
    a_rdy = 1'b1;
    tick();
    a_rdy = 1'b0;

    // Strobes every 104 clocks, random data and random consumer stalls, against the model
    begin
      int m;
      m = 0;
      for (int s = 0; s < 40; s++) begin
        for (int c = 0; c < 104; c++) begin
          b_vld = (c == 0);
          if (c == 0) begin
            b_din = 24'($urandom);
            if (m == 0) q.push_back(model_conv(b_din));
            m = (m + 1) % 4;
          end
          b_rdy = 1'($urandom_range(0, 1));
          b_check_pop("rand_dout");
          tick();
        end
      end
      b_vld = 1'b0;
      b_rdy = 1'b1;
      for (int c = 0; c < 8; c++) begin
        b_check_pop("rand_tail");
        tick();
      end
      chk("rand_all_out", 32'(q.size()), 32'd0);
      chk("rand_level",   32'(b_level),  32'd0);
      chk("rand_no_ovf",  32'(b_ovf),    32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
